// File: rtl/aes128_bus_regs.sv
// Bus register front end for the AES-128 round engine. It holds the key, data and
// result registers, sends the start handshake, and provides status, interrupt, abort and watchdog.
module aes128_bus_regs #(
   parameter int TIMEOUT_CYCLES = 2048,
   parameter int CNT_W          = 12
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [5:0]   addr_i,
   input  logic [31:0]  wdata_i,
   input  logic         wr_en_i,
   input  logic         rd_en_i,
   output logic [31:0]  rdata_o,
   output logic         rvalid_o,
   output logic         irq_o,
   output logic         start_o,
   output logic [127:0] key_o,
   output logic [127:0] data_o,
   input  logic [127:0] result_i,
   input  logic         valid_i,
   input  logic         ready_i
);

   typedef enum logic [1:0] {IDLE, REQ, RUN, CAPTURE} state_t;

   state_t           state_q, state_d;
   logic [127:0]     key_q, data_q, res_q;
   logic             ie_q, done_q, err_q;
   logic [1:0]       err_code_q, err_code_d;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      rdata_q, rd_mux;
   logic             rvalid_q;

   logic [3:0] word;
   logic [1:0] sub;
   logic       idle, sel_key, sel_data, sel_ctrl, sel_status;
   logic       ctrl_wr, status_wr, kd_wr;
   logic       start_req, abort_req, err_start_busy, err_kd_busy, timeout, err_set;
   logic       unused_addr;

   assign word        = addr_i[5:2];
   assign sub         = addr_i[3:2];
   assign unused_addr = ^addr_i[1:0];

   assign idle       = (state_q == IDLE);
   assign sel_key    = (word[3:2] == 2'b00);
   assign sel_data   = (word[3:2] == 2'b01);
   assign sel_ctrl   = (word == 4'd12);
   assign sel_status = (word == 4'd13);

   assign ctrl_wr   = wr_en_i & sel_ctrl;
   assign status_wr = wr_en_i & sel_status;
   assign kd_wr     = wr_en_i & (sel_key | sel_data);

   // Abort only has meaning while an operation is in flight; it suppresses a start bit in the same write
   assign start_req      = ctrl_wr & wdata_i[0] & idle;
   assign abort_req      = ctrl_wr & wdata_i[2] & ((state_q == REQ) | (state_q == RUN));
   assign err_start_busy = ctrl_wr & wdata_i[0] & ~idle & ~abort_req;
   assign err_kd_busy    = kd_wr & ~idle;
   assign timeout        = (state_q == RUN) & ~abort_req & ~valid_i &
                           ((cnt_q + 1'b1) == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err_set        = err_start_busy | err_kd_busy | timeout;
   assign err_code_d     = timeout ? 2'd2 : (err_kd_busy ? 2'd3 : 2'd1);

   always_comb begin
      state_d = state_q;
      start_o = 1'b0;
      case (state_q)
         IDLE:    if (start_req) state_d = REQ;
         REQ: begin
            if (abort_req) begin
               state_d = IDLE;
            end else if (ready_i) begin
               start_o = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort_req)    state_d = IDLE;
            else if (valid_i) state_d = CAPTURE;
            else if (timeout) state_d = IDLE;
         end
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (word[3:2])
         2'b00: rd_mux = key_q[{sub, 5'b0} +: 32];
         2'b01: rd_mux = data_q[{sub, 5'b0} +: 32];
         2'b10: rd_mux = res_q[{sub, 5'b0} +: 32];
         default: begin
            if (sel_ctrl)        rd_mux = {30'b0, ie_q, 1'b0};
            else if (sel_status) rd_mux = {26'b0, err_code_q, 1'b0, err_q, done_q, ~idle};
         end
      endcase
   end

   // Hardware sets of done/err take precedence over a same-cycle write-1-clear
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         key_q      <= '0;
         data_q     <= '0;
         res_q      <= '0;
         ie_q       <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q <= state_d;

         if (start_o)              cnt_q <= '0;
         else if (state_q == RUN)  cnt_q <= cnt_q + 1'b1;

         if (kd_wr && idle && sel_key)  key_q[{sub, 5'b0} +: 32]  <= wdata_i;
         if (kd_wr && idle && sel_data) data_q[{sub, 5'b0} +: 32] <= wdata_i;
         if (ctrl_wr)                   ie_q <= wdata_i[1];

         if (state_q == CAPTURE) begin
            res_q  <= result_i;
            done_q <= 1'b1;
         end else if (start_req || (status_wr && wdata_i[1])) begin
            done_q <= 1'b0;
         end

         if (err_set) begin
            err_q      <= 1'b1;
            err_code_q <= err_code_d;
         end else if (status_wr && wdata_i[2]) begin
            err_q      <= 1'b0;
            err_code_q <= '0;
         end

         rvalid_q <= rd_en_i & ~wr_en_i;
         if (rd_en_i && !wr_en_i) rdata_q <= rd_mux;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign irq_o    = ie_q & (done_q | err_q);
   assign key_o    = key_q;
   assign data_o   = data_q;

endmodule

// File: tb/tb_aes128_bus_regs.sv
// Directed bench for aes128_bus_regs. It uses a behavioural engine model, and a read scoreboard
// checks every registered read response against the value queued when the read was issued.
module tb_aes128_bus_regs;

   localparam int TIMEOUT = 16;
   localparam int ENG_LAT = 5;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk_i = 1'b0;
   logic         rst_n_i = 1'b0;
   logic [5:0]   addr_i;
   logic [31:0]  wdata_i;
   logic         wr_en_i;
   logic         rd_en_i;
   logic [31:0]  rdata_o;
   logic         rvalid_o;
   logic         irq_o;
   logic         start_o;
   logic [127:0] key_o;
   logic [127:0] data_o;
   logic [127:0] result_i;
   logic         valid_i;
   logic         ready_i;

   logic         hold_ready = 1'b0;
   logic         eng_hang = 1'b0;
   logic         eng_busy;
   logic [3:0]   eng_cnt;

   logic [31:0]  sb_q[$];
   int           checks = 0;
   int           errors = 0;

   aes128_bus_regs #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(12)) dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .wr_en_i  (wr_en_i),
      .rd_en_i  (rd_en_i),
      .rdata_o  (rdata_o),
      .rvalid_o (rvalid_o),
      .irq_o    (irq_o),
      .start_o  (start_o),
      .key_o    (key_o),
      .data_o   (data_o),
      .result_i (result_i),
      .valid_i  (valid_i),
      .ready_i  (ready_i)
   );

   always #5 clk_i = ~clk_i;

   assign ready_i = ~eng_busy & ~hold_ready;

   // Engine stand-in: it knows the FIPS-197 vector and otherwise returns a scrambled value
   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         eng_busy <= 1'b0;
         eng_cnt  <= '0;
         valid_i  <= 1'b0;
         result_i <= '0;
      end else if (start_o) begin
         eng_busy <= 1'b1;
         eng_cnt  <= 4'(ENG_LAT);
         valid_i  <= 1'b0;
      end else if (eng_busy && !eng_hang) begin
         if (eng_cnt == 0) begin
            eng_busy <= 1'b0;
            valid_i  <= 1'b1;
            result_i <= (key_o == FIPS_KEY && data_o == FIPS_PT) ? FIPS_CT :
                        (key_o ^ data_o ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969);
         end else begin
            eng_cnt <= eng_cnt - 1'b1;
         end
      end
   end

   always @(negedge clk_i) begin
      if (sb_q.size() > 0) begin
         logic [31:0] sb_exp;
         sb_exp = sb_q.pop_front();
         checks++;
         assert (rvalid_o === 1'b1 && rdata_o === sb_exp) else begin
            errors++;
            $error("FAIL read_resp observed rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                   rvalid_o, rdata_o, sb_exp);
         end
      end else begin
         checks++;
         assert (rvalid_o === 1'b0) else begin
            errors++;
            $error("FAIL rvalid_idle observed=%b expected=0", rvalid_o);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
      addr_i  = a;
      wdata_i = d;
      wr_en_i = 1'b1;
      tick();
      wr_en_i = 1'b0;
   endtask

   task automatic bus_read(input logic [5:0] a, input logic [31:0] e);
      addr_i  = a;
      rd_en_i = 1'b1;
      tick();
      rd_en_i = 1'b0;
      sb_q.push_back(e);
   endtask

   initial begin
      int starts;
      int bad;
      addr_i  = '0;
      wdata_i = '0;
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;

      $display("[TB] reset state");
      check_output("rst_rdata", rdata_o, 0);
      check_output("rst_rvalid", rvalid_o, 0);
      check_output("rst_irq", irq_o, 0);
      check_output("rst_start", start_o, 0);
      check_output("rst_key", key_o, 0);
      check_output("rst_data", data_o, 0);
      bus_read(6'h34, 32'h0);
      bus_read(6'h20, 32'h0);
      bus_read(6'h30, 32'h0);

      $display("[TB] FIPS-197 encryption");
      bus_write(6'h00, 32'h0c0d0e0f);
      bus_write(6'h04, 32'h08090a0b);
      bus_write(6'h08, 32'h04050607);
      bus_write(6'h0c, 32'h00010203);
      bus_write(6'h10, 32'hccddeeff);
      bus_write(6'h14, 32'h8899aabb);
      bus_write(6'h18, 32'h44556677);
      bus_write(6'h1c, 32'h00112233);
      check_output("key_o_loaded", key_o, FIPS_KEY);
      check_output("data_o_loaded", data_o, FIPS_PT);
      bus_read(6'h18, 32'h44556677);
      bus_write(6'h24, 32'hffffffff);
      bus_write(6'h38, 32'hffffffff);
      bus_read(6'h24, 32'h0);
      bus_read(6'h38, 32'h0);
      bus_write(6'h30, 32'h3);
      check_output("t1_start_pulse", start_o, 1);
      bus_read(6'h34, 32'h1);
      starts = 0;
      for (int i = 0; i < 40; i++) begin
         if (irq_o) break;
         tick();
         if (start_o) starts++;
      end
      check_output("t1_irq_done", irq_o, 1);
      check_output("t1_extra_start", starts, 0);
      bus_read(6'h20, 32'h70b4c55a);
      bus_read(6'h24, 32'hd8cdb780);
      bus_read(6'h28, 32'h6a7b0430);
      bus_read(6'h2c, 32'h69c4e0d8);
      bus_read(6'h34, 32'h2);
      bus_read(6'h30, 32'h2);
      bus_write(6'h34, 32'h2);
      check_output("t1_irq_cleared", irq_o, 0);
      bus_read(6'h34, 32'h0);

      $display("[TB] engine not ready");
      hold_ready = 1'b1;
      bus_write(6'h30, 32'h1);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (start_o !== 1'b0) bad++;
         tick();
      end
      check_output("t2_start_held_low", bad, 0);
      bus_read(6'h34, 32'h1);
      hold_ready = 1'b0;
      #1;
      check_output("t2_start_on_ready", start_o, 1);
      tick();
      check_output("t2_start_single", start_o, 0);
      repeat (12) tick();
      bus_read(6'h34, 32'h2);

      $display("[TB] watchdog timeout");
      eng_hang = 1'b1;
      bus_write(6'h30, 32'h3);
      check_output("t3_start_pulse", start_o, 1);
      bad = 0;
      for (int i = 1; i < TIMEOUT; i++) begin
         tick();
         if (irq_o !== 1'b0) bad++;
      end
      check_output("t3_no_early_timeout", bad, 0);
      tick();
      check_output("t3_timeout_irq", irq_o, 1);
      bus_read(6'h34, 32'h24);
      bus_read(6'h20, 32'h70b4c55a);
      eng_hang = 1'b0;
      repeat (10) tick();
      bus_read(6'h34, 32'h24);
      bus_write(6'h34, 32'h4);
      bus_read(6'h34, 32'h0);

      $display("[TB] busy errors and abort");
      bus_write(6'h10, 32'h11111111);
      eng_hang = 1'b1;
      bus_write(6'h30, 32'h1);
      check_output("t4_start_pulse", start_o, 1);
      tick();
      bus_write(6'h00, 32'hdeadbeef);
      check_output("t4_key_stable", key_o, FIPS_KEY);
      bus_read(6'h34, 32'h35);
      starts = 0;
      bus_write(6'h30, 32'h1);
      if (start_o) starts++;
      bus_read(6'h34, 32'h15);
      if (start_o) starts++;
      check_output("t4_no_restart", starts, 0);
      bus_write(6'h30, 32'h4);
      bus_read(6'h34, 32'h14);
      eng_hang = 1'b0;
      repeat (10) tick();
      bus_read(6'h20, 32'h70b4c55a);
      bus_read(6'h2c, 32'h69c4e0d8);
      bus_read(6'h34, 32'h14);

      $display("[TB] asynchronous reset mid-run");
      bus_write(6'h34, 32'h4);
      bus_write(6'h10, 32'hccddeeff);
      eng_hang = 1'b1;
      bus_write(6'h30, 32'h3);
      tick();
      bus_write(6'h04, 32'h1);
      check_output("t5_irq_before_reset", irq_o, 1);
      bus_read(6'h0c, 32'h00010203);
      @(negedge clk_i);
      #2;
      rst_n_i = 1'b0;
      #1;
      check_output("t5_rdata_async", rdata_o, 0);
      check_output("t5_rvalid_async", rvalid_o, 0);
      check_output("t5_irq_async", irq_o, 0);
      check_output("t5_start_async", start_o, 0);
      check_output("t5_key_async", key_o, 0);
      check_output("t5_data_async", data_o, 0);
      @(posedge clk_i);
      #1;
      rst_n_i  = 1'b1;
      eng_hang = 1'b0;
      bus_read(6'h34, 32'h0);
      bus_read(6'h00, 32'h0);
      bus_read(6'h30, 32'h0);

      repeat (3) tick();
      check_output("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes128_bus_regs.md
Name: aes128_bus_regs

Overview:
- Register-mapped front end that sits directly upstream of the AES-128 round engine, and also consumes the engine's result.
- Loads the 128-bit key and data block through 32-bit bus writes and drives the engine's start/key/data inputs with a one-cycle start handshake.
- Captures the engine's 128-bit result on completion and exposes it for 32-bit readback.
- Provides status flags, a completion/error interrupt, an abort, and a watchdog.

Parameters:
- TIMEOUT_CYCLES, 2048: maximum cycles in RUN before a timeout error; legal range 16..4095.
- CNT_W, 12: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- addr_i  in  6  byte address, word aligned; addr_i[1:0] is ignored.
- wdata_i  in  32  write data.
- wr_en_i  in  1  write strobe, one access per cycle.
- rd_en_i  in  1  read strobe; wr_en_i has priority if both are high.
- rdata_o  out  32  registered read data.
- rvalid_o  out  1  high for exactly 1 cycle, the cycle after rd_en_i.
- irq_o  out  1  equals ie & (done | err), decoded from registered bits.
- start_o  out  1  one-cycle start pulse to the engine.
- key_o  out  128  key register contents.
- data_o  out  128  data register contents.
- result_i  in  128  engine result.
- valid_i  in  1  engine result valid; cleared by the engine on start.
- ready_i  in  1  engine idle.

Behaviour:
- Reset (asynchronous, rst_n_i=0) clears everything to 0:
  - key, data and result registers;
  - ie, done, err and the counter;
  - FSM returns to IDLE;
  - outputs rdata_o, rvalid_o, irq_o and start_o are 0.
- Register map (word n of a 128-bit field is bits [32n+31:32n]):
  - 0x00-0x0C KEY0-3, read/write.
  - 0x10-0x1C DATA0-3, read/write.
  - 0x20-0x2C RES0-3, read-only.
  - 0x30 CTRL, write:
    - bit0 = start request;
    - bit1 = ie, stored;
    - bit2 = abort.
  - 0x30 CTRL, read: bit1 = ie; all other bits 0.
  - 0x34 STATUS, read:
    - bit0 busy, meaning state is not IDLE;
    - bit1 done;
    - bit2 err;
    - bits[5:4] err code: 1 = start while busy, 2 = timeout, 3 = write to KEY/DATA while busy.
  - 0x34 STATUS, write: writing 1 to bit1 clears done; writing 1 to bit2 clears err and the err code.
- Unmapped addresses read 0; writes to them are ignored.
- Writes to RES are ignored.
- Reads: rdata_o and rvalid_o are registered, 1-cycle latency.
  - A read returns register contents from before any write in the same cycle.
- FSM states: IDLE, REQ, RUN, CAPTURE.
- IDLE:
  - A CTRL write with bit0=1 clears done and moves to REQ.
  - If bit2 is also set, the abort is a no-op.
- REQ:
  - When ready_i=1: start_o=1 for this single cycle, clear the counter, move to RUN.
  - When ready_i=0: stay in REQ with start_o=0. No timeout applies in REQ.
- RUN:
  - The counter increments every cycle.
  - valid_i=1 moves to CAPTURE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: set err with code 2 and return to IDLE; done stays 0.
- CAPTURE (one cycle): result register <= result_i, done <= 1, return to IDLE.
- Ordering: RUN is entered on the same edge at which the engine clears valid_i, so the stale valid_i from a previous run cannot trigger CAPTURE.
- start_o is asserted only in REQ together with ready_i; it is never high for 2 consecutive cycles.
- Abort (CTRL bit2=1) in REQ or RUN:
  - returns to IDLE next cycle; no capture, done unchanged;
  - bit0 in the same write is ignored.
- CTRL bit0 written while not IDLE: the request is ignored; set err with code 1.
- KEY/DATA write while not IDLE: the write is ignored; set err with code 3.
  - key_o and data_o are stable for the whole operation.
- Error code priority: a new error overwrites the code of an uncleared one. Any err set is visible on the next cycle.
- Simultaneous events:
  - A STATUS write-1-clear in the same cycle as a hardware set of the same bit: the set wins.
  - valid_i on the same cycle as the timeout threshold: capture wins.
- Reset mid-operation:
  - Immediate return to IDLE with start_o=0; register contents are lost.
  - The engine is reset by the same rst_n_i.

Test Plan:
- Program key 0x000102030405060708090a0b0c0d0e0f (KEY0=0x0c0d0e0f ... KEY3=0x00010203), DATA 0x00112233445566778899aabbccddeeff, ie=1, start, using the real engine. Required response:
  - exactly one start_o pulse;
  - busy=1 until capture;
  - RES3..0 = 0x69c4e0d8, 0x6a7b0430, 0xd8cdb780, 0x70b4c55a;
  - done=1 and irq_o=1;
  - writing 0x2 to STATUS drops irq_o.
- Hold ready_i=0 for 50 cycles after a start write. Required response: state stays in REQ, start_o=0 throughout, no timeout; start_o pulses on the first cycle ready_i=1.
- Engine model that never asserts valid_i, with TIMEOUT_CYCLES=16. Required response: err=1 with code 2 exactly 16 cycles after the start_o cycle; busy=0; done=0; RES unchanged.
- While in RUN:
  - write KEY0=0xdeadbeef. Required response: key_o unchanged; err code 3.
  - then write CTRL=0x1. Required response: err code 1; no second start_o.
- Abort: CTRL=0x4 in RUN. Required response: IDLE the next cycle; a later valid_i=1 does not update RES or done.
- Drop rst_n_i asynchronously mid-RUN. Required response: all outputs and status are 0 immediately, before the next clock edge; after reset release, read of 0x34 returns 0 with rvalid_o one cycle after rd_en_i.
